// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: load/store unit with a variable-latency memory handshake and registered writeback.
// Define MEMWB_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are aligned down to the access size.
module mem_wb_pipe #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_ctrl,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_ctrl,
  input  logic [4:0]        rd_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   alu_in,
  input  logic [XLEN-1:0]   store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0] state;

  logic [1:0]       l_wb_ctrl;
  logic [4:0]       l_rd;
  logic [XLEN-1:0]  l_pc;
  logic [XLEN-1:0]  l_alu;
  logic [XLEN-1:0]  rdata_q;
  logic             l_store;
  logic             l_skip;
  logic             l_trap;
  logic             l_uns;
  logic [1:0]       l_size;
  logic [OFF_W-1:0] l_off;

  logic              is_mem;
  logic              illegal;
  logic              trap;
  logic              skip;
  logic [OFF_W-1:0]  low_mask;
  logic [ADDR_W-1:0] addr_al;
  logic [NB-1:0]     be_base;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_val;

  assign in_ready = (state == S_IDLE);

  // Decode of the op presented at the input: size mask, lanes, legality.
  always_comb begin
    is_mem  = mem_rd | mem_wr;
    illegal = (mem_ctrl == 3'b111) ||
              ((XLEN == 32) && ((mem_ctrl == 3'b011) || (mem_ctrl == 3'b110)));
    case (mem_ctrl[1:0])
      2'd0: begin
        low_mask = '0;
        be_base  = NB'(1);
        wdata    = {NB{store_data[7:0]}};
      end
      2'd1: begin
        low_mask = OFF_W'(1);
        be_base  = NB'(3);
        wdata    = {(NB/2){store_data[15:0]}};
      end
      2'd2: begin
        low_mask = OFF_W'(3);
        be_base  = NB'(15);
        wdata    = {(NB/4){store_data[31:0]}};
      end
      default: begin
        low_mask = OFF_W'(7);
        be_base  = '1;
        wdata    = store_data;
      end
    endcase
`ifdef MEMWB_MISALIGN_TRAP_EN
    trap = (|(alu_in[OFF_W-1:0] & low_mask)) & ~illegal;
`else
    trap = 1'b0;
`endif
    skip    = illegal | trap;
    addr_al = alu_in[ADDR_W-1:0] & ~ADDR_W'(low_mask);
    be      = be_base << addr_al[OFF_W-1:0];
  end

  // Load data path: move the addressed lane to bit 0, then extend.
  always_comb begin
    lane = rdata_q >> {l_off, 3'b000};
    case (l_size)
      2'd0:    load_val = l_uns ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
      2'd1:    load_val = l_uns ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
      2'd2:    load_val = l_uns ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
      default: load_val = lane;
    endcase
  end

  function automatic logic [XLEN-1:0] wb_sel(input logic [1:0] sel, input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld);
    case (sel)
      2'b00:   return pc;
      2'b01:   return alu;
      2'b10:   return ld;
      default: return '0;
    endcase
  endfunction

  // NOTE: the op latch and read-data capture carry no reset; they are only read after an accept refills them.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid && is_mem) begin
      l_wb_ctrl <= wb_ctrl;
      l_rd      <= rd_in;
      l_pc      <= pc_in;
      l_alu     <= alu_in;
      l_store   <= mem_wr;
      l_skip    <= skip;
      l_trap    <= trap;
      l_uns     <= mem_ctrl[2];
      l_size    <= mem_ctrl[1:0];
      l_off     <= addr_al[OFF_W-1:0];
    end
    if ((state == S_ACCESS) && !l_skip && dmem_ack) rdata_q <= dmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misalign   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && is_mem) begin
            state      <= S_ACCESS;
            dmem_req   <= ~skip;
            dmem_we    <= mem_wr & ~skip;
            dmem_addr  <= addr_al;
            dmem_be    <= be;
            dmem_wdata <= wdata;
          end else if (in_valid) begin
            wb_valid <= 1'b1;
            wb_we    <= (wb_ctrl != 2'b11) && (rd_in != 5'd0);
            wb_rd    <= rd_in;
            wb_data  <= wb_sel(wb_ctrl, pc_in, alu_in, load_val);
          end
        end
        S_ACCESS: begin
          // A skipped op has no request outstanding, so any ack is not ours.
          if (l_skip) begin
            state <= S_RESP;
          end else if (dmem_ack) begin
            state    <= S_RESP;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          wb_valid <= 1'b1;
          wb_we    <= (l_wb_ctrl != 2'b11) && !l_store && !l_skip && (l_rd != 5'd0);
          wb_rd    <= l_rd;
          wb_data  <= wb_sel(l_wb_ctrl, l_pc, l_alu, load_val);
          misalign <= l_trap;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: scoreboard of expected writebacks plus directed memory-port checks.
`timescale 1ns/1ps
module tb_mem_wb_pipe;
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, mem_rd, mem_wr, dmem_req, dmem_we, dmem_ack;
  logic        wb_valid, wb_we, misalign;
  logic [1:0]  wb_ctrl;
  logic [2:0]  mem_ctrl;
  logic [4:0]  rd_in, wb_rd;
  logic [31:0] pc_in, alu_in, store_data, dmem_wdata, dmem_rdata, wb_data;
  logic [11:0] dmem_addr;
  logic [3:0]  dmem_be;

  mem_wb_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wb_ctrl(wb_ctrl),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl), .rd_in(rd_in), .pc_in(pc_in),
    .alu_in(alu_in), .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  logic        in_valid_64, in_ready_64, dmem_req_64, dmem_we_64, dmem_ack_64;
  logic        wb_valid_64, wb_we_64, misalign_64;
  logic [2:0]  mem_ctrl_64;
  logic [4:0]  wb_rd_64;
  logic [63:0] alu_64, dmem_wdata_64, dmem_rdata_64, wb_data_64;
  logic [11:0] dmem_addr_64;
  logic [7:0]  dmem_be_64;

  mem_wb_pipe #(.XLEN(64), .ADDR_W(12)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid_64), .in_ready(in_ready_64), .wb_ctrl(2'b10),
    .mem_rd(1'b1), .mem_wr(1'b0), .mem_ctrl(mem_ctrl_64), .rd_in(5'd6), .pc_in(64'd0),
    .alu_in(alu_64), .store_data(64'd0), .dmem_req(dmem_req_64), .dmem_we(dmem_we_64),
    .dmem_addr(dmem_addr_64), .dmem_be(dmem_be_64), .dmem_wdata(dmem_wdata_64),
    .dmem_rdata(dmem_rdata_64), .dmem_ack(dmem_ack_64), .wb_valid(wb_valid_64), .wb_we(wb_we_64),
    .wb_rd(wb_rd_64), .wb_data(wb_data_64), .misalign(misalign_64)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        we;
    logic        mis;
    int          cyc;
  } wb_exp_t;

  wb_exp_t sb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // Writeback monitor: every wb_valid pulse must match the oldest expectation, at the expected cycle.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", wb_valid, 1'b0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_cycle", cyc, e.cyc);
        check("wb_rd", wb_rd, e.rd);
        check("wb_we", wb_we, e.we);
        check("misalign", misalign, e.mis);
        if (e.chk_data) check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic alu_op(input logic [1:0] wbc, input logic [4:0] rd_i, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] exp_data, input logic chk,
                        input logic exp_we);
    wb_exp_t e;
    in_valid = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; wb_ctrl = wbc;
    rd_in = rd_i; pc_in = pc; alu_in = alu;
    e.rd = rd_i; e.data = exp_data; e.chk_data = chk; e.we = exp_we; e.mis = 1'b0; e.cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic mem_op(input string tag, input logic [2:0] ctrl, input logic rd_r, input logic wr_r,
                        input logic [1:0] wbc, input logic [4:0] rd_i, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [31:0] rdata, input int ack_dly,
                        input logic exp_req, input logic [11:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data, input logic chk,
                        input logic exp_we, input logic exp_mis);
    wb_exp_t e;
    in_valid = 1'b1; mem_rd = rd_r; mem_wr = wr_r; mem_ctrl = ctrl; wb_ctrl = wbc;
    rd_in = rd_i; pc_in = 32'h0000_4000; alu_in = alu; store_data = sd;
    e.rd = rd_i; e.data = exp_data; e.chk_data = chk; e.we = exp_we; e.mis = exp_mis;
    e.cyc = cyc + 3 + (exp_req ? ack_dly : 0);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_req"}, dmem_req, exp_req);
    if (exp_req) begin
      check({tag, "_we"}, dmem_we, wr_r);
      check({tag, "_addr"}, dmem_addr, exp_addr);
      check({tag, "_be"}, dmem_be, exp_be);
      if (wr_r) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      repeat (ack_dly) begin
        @(posedge clk); #1;
      end
      check({tag, "_req_held"}, dmem_req, 1'b1);
      check({tag, "_addr_held"}, dmem_addr, exp_addr);
      dmem_ack = 1'b1; dmem_rdata = rdata;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check({tag, "_req_drop"}, dmem_req, 1'b0);
    end else begin
      check({tag, "_we"}, dmem_we, 1'b0);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic ld64(input string tag, input logic [2:0] ctrl, input logic [63:0] alu,
                      input logic [63:0] rdata, input logic [63:0] exp_data);
    in_valid_64 = 1'b1; mem_ctrl_64 = ctrl; alu_64 = alu;
    @(posedge clk); #1;
    in_valid_64 = 1'b0;
    check({tag, "_req"}, dmem_req_64, 1'b1);
    dmem_ack_64 = 1'b1; dmem_rdata_64 = rdata;
    @(posedge clk); #1;
    dmem_ack_64 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_wb_valid"}, wb_valid_64, 1'b1);
    check({tag, "_wb_we"}, wb_we_64, 1'b1);
    check({tag, "_wb_data"}, wb_data_64, exp_data);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_ctrl = 3'b000; wb_ctrl = 2'b00;
    rd_in = '0; pc_in = '0; alu_in = '0; store_data = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    in_valid_64 = 1'b0; mem_ctrl_64 = 3'b000; alu_64 = '0; dmem_rdata_64 = '0; dmem_ack_64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_dmem_addr", dmem_addr, 12'h0);
    check("rst_dmem_be", dmem_be, 4'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Non-memory ops, including back-to-back writebacks on consecutive cycles.
    alu_op(2'b01, 5'd5, 32'h0, 32'd7, 32'd7, 1'b1, 1'b1);
    alu_op(2'b01, 5'd5, 32'h0, 32'd9, 32'd9, 1'b1, 1'b1);
    alu_op(2'b00, 5'd3, 32'h1000, 32'h55, 32'h1000, 1'b1, 1'b1);
    alu_op(2'b01, 5'd0, 32'h0, 32'h77, 32'h77, 1'b1, 1'b0);
    alu_op(2'b11, 5'd4, 32'h0, 32'h88, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    //       tag    ctrl    rd    wr    wbc    rd   alu         store_data    rdata         dly req addr    be       wdata         wb_data       chk   we    mis
    mem_op("lb",   3'b000, 1'b1, 1'b0, 2'b10, 5'd7, 32'h103, 32'h0,        32'h80FF_0000, 2, 1'b1, 12'h103, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b1, 1'b0);
    mem_op("sh",   3'b001, 1'b0, 1'b1, 2'b01, 5'd8, 32'h102, 32'h0000_ABCD, 32'h0,        0, 1'b1, 12'h102, 4'b1100, 32'hABCD_ABCD, 32'h102,      1'b1, 1'b0, 1'b0);
`ifdef MEMWB_MISALIGN_TRAP_EN
    mem_op("lhu",  3'b101, 1'b1, 1'b0, 2'b10, 5'd9, 32'h101, 32'h0,        32'h1234_F00D, 1, 1'b0, 12'h0,   4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1);
`else
    mem_op("lhu",  3'b101, 1'b1, 1'b0, 2'b10, 5'd9, 32'h101, 32'h0,        32'h1234_F00D, 1, 1'b1, 12'h100, 4'b0011, 32'h0,        32'h0000_F00D, 1'b1, 1'b1, 1'b0);
`endif
    mem_op("lh",   3'b001, 1'b1, 1'b0, 2'b10, 5'd10, 32'h206, 32'h0,       32'h8001_1234, 0, 1'b1, 12'h206, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b1, 1'b1, 1'b0);
    mem_op("lbu",  3'b100, 1'b1, 1'b0, 2'b10, 5'd11, 32'h101, 32'h0,       32'h0000_A500, 1, 1'b1, 12'h101, 4'b0010, 32'h0,        32'h0000_00A5, 1'b1, 1'b1, 1'b0);
    mem_op("lw",   3'b010, 1'b1, 1'b0, 2'b10, 5'd12, 32'h208, 32'h0,       32'h8000_0001, 3, 1'b1, 12'h208, 4'b1111, 32'h0,        32'h8000_0001, 1'b1, 1'b1, 1'b0);
    mem_op("sb_rw",3'b000, 1'b1, 1'b1, 2'b01, 5'd13, 32'h3,   32'h1234_565A, 32'h0,       0, 1'b1, 12'h003, 4'b1000, 32'h5A5A_5A5A, 32'h3,        1'b1, 1'b0, 1'b0);
    mem_op("sw",   3'b010, 1'b0, 1'b1, 2'b01, 5'd14, 32'h8,   32'hDEAD_BEEF, 32'h0,       1, 1'b1, 12'h008, 4'b1111, 32'hDEAD_BEEF, 32'h8,        1'b1, 1'b0, 1'b0);
    mem_op("ill7", 3'b111, 1'b1, 1'b0, 2'b10, 5'd15, 32'h10,  32'h0,       32'h0,         0, 1'b0, 12'h0,   4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
    mem_op("ill3", 3'b011, 1'b1, 1'b0, 2'b10, 5'd16, 32'h18,  32'h0,       32'h0,         0, 1'b0, 12'h0,   4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
    mem_op("lw_r0",3'b010, 1'b1, 1'b0, 2'b10, 5'd0,  32'h20,  32'h0,       32'h0000_0055, 0, 1'b1, 12'h020, 4'b1111, 32'h0,        32'h0000_0055, 1'b1, 1'b0, 1'b0);

    // Reset while an access waits for its ack, then a stray ack right after reset.
    in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_ctrl = 3'b010; wb_ctrl = 2'b10;
    rd_in = 5'd17; alu_in = 32'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstacc_req_before", dmem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstacc_req", dmem_req, 1'b0);
    check("rstacc_in_ready", in_ready, 1'b1);
    check("rstacc_wb_valid", wb_valid, 1'b0);
    check("rstacc_addr", dmem_addr, 12'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("stray_ack_in_ready", in_ready, 1'b1);
    check("stray_ack_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    check("stray_ack_wb_valid", wb_valid, 1'b0);

    // 64-bit datapath loads.
    ld64("lwu64", 3'b110, 64'h0, 64'hFFFF_FFFF_8000_0001, 64'h0000_0000_8000_0001);
    ld64("lw64",  3'b010, 64'h0, 64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0001);
    ld64("ld64",  3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
